mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-ported word memory.
//
// Each port issues a request (req/we/addr/be/wdata). The arbiter grants at most
// one port per cycle and forwards that port's command onto the mem_* bus in the
// same cycle. Read data returns one cycle later on the owning port's
// rvalid/rdata.
//
// Handshake: pN_req is a level held by the requester until pN_gnt is seen high
// in the same cycle; the command fields must stay stable while req is high. A
// grant is the completion of a write. For a read, the grant is followed exactly
// one cycle later by pN_rvalid with pN_rdata, and that return cannot be
// back-pressured.
//
// Parameters: ADDR_WIDTH (word address bits), BYTES_PER_WORD (data is 8x this),
//   STARVE_LIMIT (1..255, denied cycles of port 1 before it is forced through).
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   lock                1 = only port 1 may be granted
//   pN_req/we/addr/be/wdata   port N command inputs
//   pN_gnt              grant, same cycle as the memory access
//   pN_rvalid/rdata     read return, one cycle after a granted read
//   mem_en/we/addr/be/wdata   memory command (all zero when idle)
//   mem_rdata           memory read data, one cycle after a read strobe
//   rd_state            debug view of the read tracking state (0 IDLE, 1 RD0, 2 RD1)
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration when
// unlocked; by default port 0 has fixed priority with port-1 starvation relief.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int BYTES_PER_WORD = 4,
  parameter int STARVE_LIMIT   = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lock,
  input  logic                        p0_req,
  input  logic                        p1_req,
  input  logic                        p0_we,
  input  logic                        p1_we,
  input  logic [ADDR_WIDTH-1:0]       p0_addr,
  input  logic [ADDR_WIDTH-1:0]       p1_addr,
  input  logic [BYTES_PER_WORD-1:0]   p0_be,
  input  logic [BYTES_PER_WORD-1:0]   p1_be,
  input  logic [8*BYTES_PER_WORD-1:0] p0_wdata,
  input  logic [8*BYTES_PER_WORD-1:0] p1_wdata,
  output logic                        p0_gnt,
  output logic                        p1_gnt,
  output logic                        p0_rvalid,
  output logic                        p1_rvalid,
  output logic [8*BYTES_PER_WORD-1:0] p0_rdata,
  output logic [8*BYTES_PER_WORD-1:0] p1_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [BYTES_PER_WORD-1:0]   mem_be,
  output logic [8*BYTES_PER_WORD-1:0] mem_wdata,
  input  logic [8*BYTES_PER_WORD-1:0] mem_rdata,
  output logic [1:0]                  rd_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } rd_state_t;

  rd_state_t state;

`ifdef MEM_ARBITER_RR_EN
  // Port that wins the next contended cycle (the one not granted most recently).
  logic rr_ptr;
`else
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;
`endif

  // Grant decision. Everything is forced low while reset is asserted so the
  // memory sees no strobe during reset.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst) begin
      if (lock) begin
        p1_gnt = p1_req;
      end else if (p0_req && p1_req) begin
`ifdef MEM_ARBITER_RR_EN
        if (rr_ptr) p1_gnt = 1'b1;
        else        p0_gnt = 1'b1;
`else
        if (starve_cnt == LIMIT) p1_gnt = 1'b1;
        else                     p0_gnt = 1'b1;
`endif
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // Command mux; the bus is held at zero when nothing is granted.
  always_comb begin
    mem_en    = p0_gnt | p1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_be    = p0_be;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_be    = p1_be;
      mem_wdata = p1_wdata;
    end
  end

  // Read tracking and arbitration history. The tracking state records only the
  // owner of the read issued this cycle, so a read in flight always returns to
  // its owner regardless of what lock or the requests do next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
      rr_ptr <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      if (p0_gnt && !p0_we)      state <= RD0;
      else if (p1_gnt && !p1_we) state <= RD1;
      else                       state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
      if (p0_gnt)      rr_ptr <= 1'b1;
      else if (p1_gnt) rr_ptr <= 1'b0;
`else
      // Counts consecutive cycles port 1 waited; saturates at the limit, which
      // is the value that hands port 1 the next contended cycle.
      if (p1_req && !p1_gnt) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= '0;
      end
`endif
    end
  end

  assign p0_rvalid = rst && (state == RD0);
  assign p1_rvalid = rst && (state == RD1);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;
  assign rd_state  = state;

endmodule
